config_source_arbiter: RTL and testbench
========================================

Name: config_source_arbiter

Overview:
- Shares the single fabric configuration-word interface (32-bit word + 1-cycle strobe) between up to NUM_SRC bitstream sources (e.g. JTAG shifter, UART loader, USB loader).
- A source claims the interface with its first strobe and owns it for the whole bitstream session.
- The session ends when the owner's finished level rises or when the owner stays silent too long; the arbiter then releases ownership.
- Sits between the per-source word extractors and the frame/config-register writer.

Parameters:
- NUM_SRC, 3, number of requesting sources (2..8).
- DATA_W, 32, configuration word width.
- IDLE_TIMEOUT, 50, cycles without an owner strobe before forced release (≥2).
- TO_W, 6, timeout counter width; must hold IDLE_TIMEOUT.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- src_strobe  in  NUM_SRC  per-source word-valid pulse.
- src_data  in  NUM_SRC*DATA_W  per-source word; source i at [i*DATA_W +: DATA_W].
- src_finished  in  NUM_SRC  per-source session-finished level (sticky until that source resets).
- cfg_strobe  out  1  registered word strobe to config writer.
- cfg_data  out  DATA_W  registered word to config writer.
- grant  out  NUM_SRC  one-hot current owner; 0 when idle.
- busy  out  1  high while a session is owned.
- session_done  out  1  1-cycle pulse on normal release (owner's finished rose).
- timeout  out  1  1-cycle pulse on forced release.
- reject  out  NUM_SRC  1-cycle pulse per non-owner strobe dropped while busy or in RELEASE.

Behaviour:
- Reset values:
  - cfg_strobe=0, cfg_data=0, grant=0, busy=0, session_done=0, timeout=0, reject=0.
  - State=IDLE, rr_ptr=0, timeout counter=0, finished-edge registers=0.
- finished_q registers src_finished every cycle. fin_rise[i] = src_finished[i] & ~finished_q[i].
- IDLE:
  - Eligible requesters = src_strobe & ~src_finished.
  - If any are eligible, pick one round-robin, starting the search at rr_ptr. Set grant to that one-hot, go to OWNED, load counter=IDLE_TIMEOUT.
  - The claiming word is forwarded: cfg_data/cfg_strobe update on the next edge, so latency is 1 cycle.
  - rr_ptr is set to (winner+1) mod NUM_SRC.
  - Losing simultaneous strobes pulse reject.
  - Strobes from sources whose finished is high are ignored silently (no reject).
- OWNED:
  - Owner strobe: cfg_data<=owner word, cfg_strobe<=1, counter reloads IDLE_TIMEOUT.
  - No owner strobe: cfg_strobe<=0; counter decrements, saturating at 0.
  - Non-owner strobes pulse reject and their data is dropped.
  - If fin_rise[owner]: go to RELEASE with session_done pulse. This has priority over timeout.
    - If the owner also strobes in the same cycle, that word is still forwarded.
  - Else if the counter equals 1 and there is no owner strobe: go to RELEASE with timeout pulse.
- RELEASE (exactly 1 cycle):
  - grant=0, busy=0, cfg_strobe=0.
  - Strobes arriving in this cycle pulse reject. Return to IDLE.
  - This guarantees at least one idle cycle between sessions.
- Outputs:
  - busy = (state==OWNED); grant is registered and matches state.
  - cfg_data holds its last value when no strobe is issued.
- Owner's finished already high at claim: impossible by the eligibility rule.
- Reset mid-session: synchronous reset drops ownership immediately with no session_done or timeout pulse.
  - A cfg_strobe pending for the next edge is suppressed.
- NUM_SRC=1: the round-robin degenerates, grant=1 whenever busy.

Decomposition:
- Shared package cfg_arb_pkg:
  - State encoding (IDLE=2'd0, OWNED=2'd1, RELEASE=2'd2).
  - Default DATA_W=32.
  - Sync-word constants FAB2/FAB3 (16'hFAB2, 16'hFAB3) for the source shifters.
- One sub-module: rr_pick (combinational round-robin one-hot picker, inputs req and ptr, output onehot and index).
- Counter, state machine and output registers stay in the top module.

Test Plan:
1. Single session:
   - Stimulus: src1 strobes 0xDEADBEEF, 0x12345678 two cycles apart, then src_finished[1] rises.
   - Required: grant=3'b010; cfg_strobe with matching data 1 cycle after each strobe; session_done pulses once; busy falls; grant=0 one cycle later.
2. Simultaneous claim:
   - Stimulus: from reset, src0 and src2 strobe in the same cycle.
   - Required: src0 wins, reject[2] pulses. Next session with the same contention: src2 wins (rr_ptr=1 skips to 2).
3. Timeout:
   - Stimulus: src2 claims and goes silent, with IDLE_TIMEOUT=50.
   - Required: timeout pulses exactly 50 cycles after the last owner strobe; no session_done; src0 can claim two cycles later.
4. Intrusion:
   - Stimulus: while src0 owns, src1 strobes 0xAAAA5555.
   - Required: reject[1] pulses; cfg_data unchanged; owner counter not reloaded.
5. Edge cases:
   - Owner strobes 0xFFFF0000 in the same cycle its finished rises: the word is forwarded and session_done pulses (no timeout).
   - A source with finished already high strobes in IDLE: no grant, no reject.
6. Reset mid-session:
   - Stimulus: reset asserted for 1 cycle while src1 owns and strobes.
   - Required: all outputs 0 the next cycle; no pulses; a new claim is accepted right after reset deasserts.

Source files
------------

// File: rtl/config_source_arbiter_pkg.sv
// cfg_arb_pkg: definitions shared by the configuration source arbiter.
//   state_t        arbiter FSM state encoding (IDLE / OWNED / RELEASE)
//   DEFAULT_DATA_W default configuration word width
//   SYNC_FAB2/3    sync-word constants used by the per-source word shifters
package cfg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWNED   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_W = 32;

    localparam logic [15:0] SYNC_FAB2 = 16'hFAB2;
    localparam logic [15:0] SYNC_FAB3 = 16'hFAB3;

endpackage

// File: rtl/config_source_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req    in  NUM_SRC  request vector
//   ptr    in  IW       index where the search starts (highest priority)
//   onehot out NUM_SRC  one-hot winner, 0 when no request
//   index  out IW       binary index of the winner, 0 when no request
module rr_pick #(
    parameter int NUM_SRC = 3,
    parameter int IW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_SRC-1:0] onehot,
    output logic [IW-1:0]      index
);

    int          j;
    logic [IW-1:0] idx;
    logic        found;

    // Walk the requesters starting at ptr, wrapping once around the ring.
    always_comb begin
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        j      = 0;
        idx    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_SRC) begin
                j = j - NUM_SRC;
            end
            idx = IW'(j);
            if (!found && req[idx]) begin
                found       = 1'b1;
                onehot[idx] = 1'b1;
                index       = idx;
            end
        end
    end

endmodule

// File: rtl/config_source_arbiter.sv
// config_source_arbiter: shares the fabric configuration-word interface between
// NUM_SRC bitstream sources. The first eligible strobe claims the interface for
// a whole session; the session ends when the owner's finished level rises or
// after IDLE_TIMEOUT cycles without an owner strobe, followed by one RELEASE
// cycle before a new claim can be accepted.
//
// Handshake: every src_strobe / cfg_strobe is a single-cycle valid with no
// ready; a word is accepted exactly in the cycle its strobe is high, and any
// strobe that cannot be forwarded is dropped and reported on reject.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   src_strobe/data     per-source word pulse and word (source i at [i*DATA_W +: DATA_W])
//   src_finished        per-source session-finished level
//   cfg_strobe/data     registered word to the config writer (1-cycle latency)
//   grant               one-hot owner, 0 when idle
//   busy                high while a session is owned
//   session_done        pulse on normal release
//   timeout             pulse on forced release
//   reject              pulse per dropped non-owner strobe
module config_source_arbiter
    import cfg_arb_pkg::*;
#(
    parameter int NUM_SRC      = 3,
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int IDLE_TIMEOUT = 50,
    parameter int TO_W         = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        src_strobe,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_finished,
    output logic                      cfg_strobe,
    output logic [DATA_W-1:0]         cfg_data,
    output logic [NUM_SRC-1:0]        grant,
    output logic                      busy,
    output logic                      session_done,
    output logic                      timeout,
    output logic [NUM_SRC-1:0]        reject
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    state_t              state, state_nxt;
    logic [NUM_SRC-1:0]  finished_q, fin_rise, eligible;
    logic [NUM_SRC-1:0]  pick_onehot;
    logic [IW-1:0]       pick_index;
    logic [IW-1:0]       rr_ptr, rr_ptr_nxt;
    logic [IW-1:0]       owner, owner_nxt;
    logic [TO_W-1:0]     count, count_nxt;
    logic [DATA_W-1:0]   pick_word, owner_word, cfg_data_nxt;
    logic                owner_strobe;
    logic                cfg_strobe_nxt, session_done_nxt, timeout_nxt;
    logic [NUM_SRC-1:0]  grant_nxt, reject_nxt;

    assign fin_rise     = src_finished & ~finished_q;
    // Sources that already finished may not start a new session.
    assign eligible     = src_strobe & ~src_finished;
    assign pick_word    = src_data[int'(pick_index)*DATA_W +: DATA_W];
    assign owner_word   = src_data[int'(owner)*DATA_W +: DATA_W];
    assign owner_strobe = src_strobe[owner];
    assign busy         = (state == ST_OWNED);

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IW      (IW)
    ) u_rr_pick (
        .req    (eligible),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .index  (pick_index)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        cfg_strobe_nxt   = 1'b0;
        cfg_data_nxt     = cfg_data;
        grant_nxt        = grant;
        session_done_nxt = 1'b0;
        timeout_nxt      = 1'b0;
        reject_nxt       = '0;
        rr_ptr_nxt       = rr_ptr;
        owner_nxt        = owner;
        count_nxt        = count;
        case (state)
            ST_IDLE: begin
                if (|eligible) begin
                    state_nxt      = ST_OWNED;
                    grant_nxt      = pick_onehot;
                    owner_nxt      = pick_index;
                    rr_ptr_nxt     = (pick_index == IW'(NUM_SRC - 1)) ? '0 : pick_index + 1'b1;
                    count_nxt      = TO_W'(IDLE_TIMEOUT);
                    cfg_strobe_nxt = 1'b1;
                    cfg_data_nxt   = pick_word;
                    reject_nxt     = eligible & ~pick_onehot;
                end
            end
            ST_OWNED: begin
                reject_nxt = src_strobe & ~grant;
                if (owner_strobe) begin
                    cfg_strobe_nxt = 1'b1;
                    cfg_data_nxt   = owner_word;
                    count_nxt      = TO_W'(IDLE_TIMEOUT);
                end else if (count != '0) begin
                    count_nxt = count - 1'b1;
                end
                // A finished edge wins over a simultaneous timeout; a word
                // strobed in the same cycle is still forwarded above.
                if (fin_rise[owner]) begin
                    state_nxt        = ST_RELEASE;
                    grant_nxt        = '0;
                    session_done_nxt = 1'b1;
                    count_nxt        = '0;
                end else if (!owner_strobe && count == TO_W'(1)) begin
                    state_nxt   = ST_RELEASE;
                    grant_nxt   = '0;
                    timeout_nxt = 1'b1;
                    count_nxt   = '0;
                end
            end
            ST_RELEASE: begin
                reject_nxt = src_strobe;
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            finished_q   <= '0;
            cfg_strobe   <= 1'b0;
            cfg_data     <= '0;
            grant        <= '0;
            session_done <= 1'b0;
            timeout      <= 1'b0;
            reject       <= '0;
            rr_ptr       <= '0;
            owner        <= '0;
            count        <= '0;
        end else begin
            finished_q   <= src_finished;
            cfg_strobe   <= cfg_strobe_nxt;
            cfg_data     <= cfg_data_nxt;
            grant        <= grant_nxt;
            session_done <= session_done_nxt;
            timeout      <= timeout_nxt;
            reject       <= reject_nxt;
            rr_ptr       <= rr_ptr_nxt;
            owner        <= owner_nxt;
            count        <= count_nxt;
        end
    end

endmodule

// File: tb/tb_config_source_arbiter.sv
// Self-checking bench for config_source_arbiter (NUM_SRC=3, DATA_W=32,
// IDLE_TIMEOUT=50). A session-level reference model predicts each cycle's
// outputs and forwarded words; a monitor compares them against the DUT.
module tb_config_source_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int TO = 50;

    typedef struct packed {
        logic          stb;
        logic [DW-1:0] data;
        logic [N-1:0]  grant;
        logic          busy;
        logic          sd;
        logic          to;
        logic [N-1:0]  rej;
    } ctl_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      src_strobe = '0;
    logic [N*DW-1:0]   src_data = '0;
    logic [N-1:0]      src_finished = '0;
    logic              cfg_strobe;
    logic [DW-1:0]     cfg_data;
    logic [N-1:0]      grant;
    logic              busy;
    logic              session_done;
    logic              timeout;
    logic [N-1:0]      reject;

    logic [DW-1:0] exp_q[$];
    ctl_t          ctl_q[$];
    int            checks = 0;
    int            errors = 0;

    config_source_arbiter #(
        .NUM_SRC      (N),
        .DATA_W       (DW),
        .IDLE_TIMEOUT (TO),
        .TO_W         (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .src_strobe   (src_strobe),
        .src_data     (src_data),
        .src_finished (src_finished),
        .cfg_strobe   (cfg_strobe),
        .cfg_data     (cfg_data),
        .grant        (grant),
        .busy         (busy),
        .session_done (session_done),
        .timeout      (timeout),
        .reject       (reject)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [N-1:0] stb, input logic [N-1:0] fin,
                         input int ws, input logic [DW-1:0] w);
        @(negedge clk);
        src_strobe   = stb;
        src_finished = fin;
        src_data     = {$urandom(), $urandom(), $urandom()};
        if (ws >= 0) src_data[ws*DW +: DW] = w;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Session-level view: who owns, how long the owner has been silent,
    // whether the mandatory release cycle is pending.
    initial begin : model
        int            owner, rr, silent, win;
        bit            in_rel, ostb;
        logic [N-1:0]  prev_fin, rise;
        logic [DW-1:0] hold;
        ctl_t          e;
        owner = -1; rr = 0; silent = 0; in_rel = 0; prev_fin = '0; hold = '0;
        forever begin
            @(posedge clk);
            e = '0;
            if (reset) begin
                owner = -1; rr = 0; silent = 0; in_rel = 0; prev_fin = '0; hold = '0;
            end else begin
                rise = src_finished & ~prev_fin;
                if (in_rel) begin
                    e.rej  = src_strobe;
                    in_rel = 0;
                end else if (owner < 0) begin
                    win = -1;
                    for (int k = 0; k < N; k++) begin
                        if (win < 0 && src_strobe[(rr + k) % N] && !src_finished[(rr + k) % N])
                            win = (rr + k) % N;
                    end
                    if (win >= 0) begin
                        owner  = win;
                        rr     = (win + 1) % N;
                        silent = 0;
                        hold   = src_data[win*DW +: DW];
                        e.stb  = 1'b1;
                        exp_q.push_back(hold);
                        e.rej  = (src_strobe & ~src_finished) & ~(N'(1) << win);
                    end
                end else begin
                    e.rej = src_strobe & ~(N'(1) << owner);
                    ostb  = src_strobe[owner];
                    if (ostb) begin
                        hold   = src_data[owner*DW +: DW];
                        e.stb  = 1'b1;
                        exp_q.push_back(hold);
                        silent = 0;
                    end else begin
                        silent++;
                    end
                    if (rise[owner]) begin
                        e.sd = 1'b1; owner = -1; in_rel = 1;
                    end else if (!ostb && silent >= TO) begin
                        e.to = 1'b1; owner = -1; in_rel = 1;
                    end
                end
                prev_fin = src_finished;
            end
            e.data  = hold;
            e.grant = (owner >= 0) ? (N'(1) << owner) : '0;
            e.busy  = (owner >= 0);
            ctl_q.push_back(e);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        ctl_t          e;
        logic [DW-1:0] w;
        forever begin
            @(posedge clk);
            #1;
            if (ctl_q.size() > 0) begin
                e = ctl_q.pop_front();
                chk("cfg_strobe", 32'(cfg_strobe), 32'(e.stb));
                chk("cfg_data", cfg_data, e.data);
                chk("grant", 32'(grant), 32'(e.grant));
                chk("busy", 32'(busy), 32'(e.busy));
                chk("session_done", 32'(session_done), 32'(e.sd));
                chk("timeout", 32'(timeout), 32'(e.to));
                chk("reject", 32'(reject), 32'(e.rej));
                if (e.stb) begin
                    w = exp_q.pop_front();
                    if (cfg_strobe === 1'b1) chk("fwd_word", cfg_data, w);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int            to_at;
        int            rate, len;
        logic [N-1:0]  stb, fin;
        int            rates[3];
        rates[0] = 30; rates[1] = 4; rates[2] = 0;

        repeat (3) drive('0, '0, -1, '0);
        reset = 1'b0;
        settle();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cfg_data", cfg_data, 0);

        // single session by src1
        drive(3'b010, 3'b000, 1, 32'hDEADBEEF); settle();
        chk("t1_grant", 32'(grant), 32'b010);
        chk("t1_word0", cfg_data, 32'hDEADBEEF);
        drive('0, '0, -1, '0);
        drive(3'b010, 3'b000, 1, 32'h12345678); settle();
        chk("t1_word1", cfg_data, 32'h12345678);
        drive('0, '0, -1, '0);
        drive('0, 3'b010, -1, '0); settle();
        chk("t1_done", 32'(session_done), 1);
        chk("t1_busy_fall", 32'(busy), 0);
        drive('0, 3'b010, -1, '0); settle();
        chk("t1_done_once", 32'(session_done), 0);
        chk("t1_grant_idle", 32'(grant), 0);
        drive('0, '0, -1, '0);

        // simultaneous claim from reset
        reset = 1'b1; drive('0, '0, -1, '0); settle(); reset = 1'b0;
        drive(3'b101, 3'b000, -1, '0); settle();
        chk("t2_win0", 32'(grant), 32'b001);
        chk("t2_rej2", 32'(reject), 32'b100);
        drive('0, 3'b001, -1, '0);
        drive('0, 3'b001, -1, '0);
        drive(3'b101, 3'b000, -1, '0); settle();
        chk("t2_win2", 32'(grant), 32'b100);
        chk("t2_rej0", 32'(reject), 32'b001);
        drive('0, 3'b100, -1, '0);
        drive('0, 3'b100, -1, '0);
        drive('0, '0, -1, '0);

        // timeout
        drive(3'b100, 3'b000, 2, $urandom()); settle();
        for (int k = 1; k <= TO; k++) begin
            drive('0, '0, -1, '0); settle();
            chk("t3_timeout", 32'(timeout), (k == TO) ? 1 : 0);
        end
        chk("t3_no_done", 32'(session_done), 0);
        drive('0, '0, -1, '0);
        drive(3'b001, 3'b000, 0, 32'h0000C0DE); settle();
        chk("t3_reclaim", 32'(grant), 32'b001);

        // intrusion while src0 owns
        for (int k = 1; k <= 10; k++) drive('0, '0, -1, '0);
        drive(3'b010, 3'b000, 1, 32'hAAAA5555); settle();
        chk("t4_rej1", 32'(reject), 32'b010);
        chk("t4_data_kept", cfg_data, 32'h0000C0DE);
        to_at = -1;
        for (int k = 12; k <= 60; k++) begin
            drive('0, '0, -1, '0); settle();
            if (timeout === 1'b1 && to_at < 0) to_at = k;
        end
        chk("t4_no_reload", 32'(to_at), TO);

        // owner strobes as finished rises; finished source strobes in IDLE
        drive(3'b010, 3'b000, 1, $urandom());
        drive('0, '0, -1, '0);
        drive(3'b010, 3'b010, 1, 32'hFFFF0000); settle();
        chk("t5_word", cfg_data, 32'hFFFF0000);
        chk("t5_strobe", 32'(cfg_strobe), 1);
        chk("t5_done", 32'(session_done), 1);
        chk("t5_no_to", 32'(timeout), 0);
        drive('0, 3'b010, -1, '0);
        drive(3'b010, 3'b010, 1, $urandom()); settle();
        chk("t5_fin_grant", 32'(grant), 0);
        chk("t5_fin_rej", 32'(reject), 0);
        drive('0, '0, -1, '0);

        // reset mid-session
        drive(3'b010, 3'b000, 1, $urandom()); settle();
        reset = 1'b1;
        drive(3'b010, 3'b000, 1, $urandom()); settle();
        chk("t6_grant", 32'(grant), 0);
        chk("t6_strobe", 32'(cfg_strobe), 0);
        chk("t6_pulses", {29'd0, session_done, timeout, busy}, 0);
        chk("t6_reject", 32'(reject), 0);
        reset = 1'b0;
        drive(3'b010, 3'b000, 1, 32'h11112222); settle();
        chk("t6_claim", 32'(grant), 32'b010);
        chk("t6_word", cfg_data, 32'h11112222);
        drive('0, 3'b010, -1, '0);
        drive('0, 3'b010, -1, '0);
        drive('0, '0, -1, '0);

        // randomized traffic
        fin = '0;
        for (int s = 0; s < 40; s++) begin
            rate = rates[$urandom_range(0, 2)];
            len  = $urandom_range(20, 80);
            for (int c = 0; c < len; c++) begin
                for (int i = 0; i < N; i++) begin
                    stb[i] = ($urandom_range(0, 99) < rate);
                    if ($urandom_range(0, 99) < 2) fin[i] = ~fin[i];
                end
                reset = ($urandom_range(0, 999) < 3);
                drive(stb, fin, -1, '0);
            end
        end
        reset = 1'b0;
        repeat (5) drive('0, '0, -1, '0);
        settle();
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
